fetch_buffer: RTL and testbench

Instruction-fetch front end directly upstream of the instruction TIM/cache. It generates sequential word fetch requests on a mem_in_type port into the TIM and accepts in-order responses on mem_out_type. It queues returned instructions with their PCs in a small FIFO for decode. It handles redirects (branch/trap) by flushing and discarding stale responses, and forwards fence.i as a fence request.

---
 rtl/fetch_buffer_pkg.sv | 44 ++++
 rtl/fetch_buffer_if.sv | 17 +
 rtl/fetch_buffer_fifo.sv | 75 +++++++
 rtl/fetch_buffer.sv | 151 +++++++++++++++
 tb/tb_fetch_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
//==============================================================================
// Module   : fetch_buffer_pkg
// Purpose  : Configuration constants, bus/entry types and FSM encoding for the
//            instruction fetch buffer.
// Revision : 1.0 - initial release
//==============================================================================
package fetch_buffer_pkg;

    // Configuration
    localparam int          FB_DEPTH = 2;          // log2 of FIFO entries
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Fetch FSM encoding
    localparam logic [1:0] c_st_fetch      = 2'd0;
    localparam logic [1:0] c_st_wait       = 2'd1;
    localparam logic [1:0] c_st_fence      = 2'd2;
    localparam logic [1:0] c_st_fence_wait = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fb_entry_type;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    // Sequential word step; wraps silently at 2**32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
//==============================================================================
// Module   : fetch_buffer_if
// Purpose  : Request/response bundle between the fetch buffer and the TIM.
// Revision : 1.0 - initial release
//==============================================================================
interface fetch_buffer_if;
    import fetch_buffer_pkg::*;

    mem_in_type  imem_in;
    mem_out_type imem_out;

    modport master (output imem_in, input  imem_out);
    modport slave  (input  imem_in, output imem_out);

endinterface
`default_nettype wire

// File: rtl/fetch_buffer_fifo.sv
`default_nettype none
//==============================================================================
// Module   : fetch_fifo
// Purpose  : Small instruction queue with flush; registered storage and a
//            combinational head read.
// Revision : 1.0 - initial release
//==============================================================================
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = FB_DEPTH
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                flush,
    input  wire logic                push,
    input  wire fb_entry_type        push_entry,
    input  wire logic                pop,
    output fb_entry_type             head,
    output logic                     valid,
    output logic [DEPTH_LOG2:0]      count
);

    localparam int                    c_entries = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_cnt_one = (DEPTH_LOG2 + 1)'(1);

    fb_entry_type              r_mem [c_entries];
    logic [DEPTH_LOG2-1:0]     r_wr_ptr;
    logic [DEPTH_LOG2-1:0]     r_rd_ptr;
    logic [DEPTH_LOG2:0]       r_count;
    logic                      w_pop;
    logic                      w_push;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Flush wins over any same-cycle push or pop.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
//==============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction fetch front end: sequential TIM requests, in-order
//            response queueing, redirect flush/discard and fence.i forwarding.
// Revision : 1.0 - initial release
//==============================================================================
module fetch_buffer
    import fetch_buffer_pkg::*;
(
    input  wire logic               rst,
    input  wire logic               clk,
    input  wire logic               redir_valid,
    input  wire logic [31:0]        redir_pc,
    input  wire logic               fence_valid,
    output logic                    fence_done,
    output logic                    inst_valid,
    input  wire logic               inst_ready,
    output logic [31:0]             inst_pc,
    output logic [31:0]             inst_data,
    fetch_buffer_if.master          imem
);

    localparam logic [FB_DEPTH+1:0] c_fifo_entries = (FB_DEPTH + 2)'(1 << FB_DEPTH);

    logic [1:0]          r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_req_pc;
    logic                r_discard;
    logic                r_fence_pend;
    logic                r_fence_done;

    logic                w_outstanding;
    logic [FB_DEPTH+1:0] w_used;
    logic                w_credit;
    logic                w_issue_fetch;
    logic                w_issue_fence;
    logic                w_rsp;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_redir_target;
    fb_entry_type        w_push_entry;
    fb_entry_type        w_head;
    logic                w_fifo_valid;
    logic [FB_DEPTH:0]   w_count;
    mem_in_type          w_mem_in;

    assign w_rsp          = imem.imem_out.mem_ready;
    assign w_redir_target = redir_pc & ~32'h3;
    assign w_outstanding  = (r_state == c_st_wait);
    assign w_used         = {1'b0, w_count} + {{(FB_DEPTH + 1){1'b0}}, w_outstanding};
    assign w_credit       = (w_used < c_fifo_entries);

    // No fetch issues in a redirect cycle so the next request uses the new pc.
    assign w_issue_fetch = rst && (r_state == c_st_fetch) && !r_fence_pend
                           && w_credit && !redir_valid;
    assign w_issue_fence = rst && (r_state == c_st_fence);

    assign w_push = rst && (r_state == c_st_wait) && w_rsp && !r_discard && !redir_valid;
    assign w_pop  = inst_valid && inst_ready;

    assign w_push_entry.pc   = r_req_pc;
    assign w_push_entry.data = imem.imem_out.mem_rdata;

    fetch_fifo #(
        .DEPTH_LOG2 (FB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redir_valid),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .valid      (w_fifo_valid),
        .count      (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_fetch;
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_discard    <= 1'b0;
            r_fence_pend <= 1'b0;
            r_fence_done <= 1'b0;
        end else begin
            r_fence_done <= 1'b0;

            if (r_state == c_st_fence) begin
                r_fence_pend <= 1'b0;
            end else if (fence_valid) begin
                r_fence_pend <= 1'b1;
            end

            case (r_state)
                c_st_fetch: begin
                    if (r_fence_pend) begin
                        r_state <= c_st_fence;
                    end else if (w_issue_fetch) begin
                        r_req_pc <= r_pc;
                        r_pc     <= next_pc(r_pc);
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (w_rsp) begin
                        r_discard <= 1'b0;
                        r_state   <= r_fence_pend ? c_st_fence : c_st_fetch;
                    end else if (redir_valid) begin
                        // The in-flight response belongs to the old stream.
                        r_discard <= 1'b1;
                    end
                end
                c_st_fence: begin
                    r_state <= c_st_fence_wait;
                end
                c_st_fence_wait: begin
                    if (w_rsp) begin
                        r_fence_done <= 1'b1;
                        r_state      <= c_st_fetch;
                    end
                end
                default: begin
                    r_state <= c_st_fetch;
                end
            endcase

            if (redir_valid) begin
                r_pc <= w_redir_target;
            end
        end
    end

    always_comb begin
        w_mem_in           = '0;
        w_mem_in.mem_valid = w_issue_fetch || w_issue_fence;
        w_mem_in.mem_fence = w_issue_fence;
        w_mem_in.mem_addr  = w_issue_fetch ? r_pc : 32'h0;
    end

    assign imem.imem_in = w_mem_in;

    // Outputs held at zero while reset is asserted and when the queue is empty.
    assign inst_valid = rst && w_fifo_valid;
    assign inst_pc    = inst_valid ? w_head.pc   : 32'h0;
    assign inst_data  = inst_valid ? w_head.data : 32'h0;
    assign fence_done = r_fence_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
//==============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Self-checking bench for fetch_buffer with a TIM model and an
//            in-order scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        fence_valid = 1'b0;
    logic        inst_ready = 1'b0;
    logic        fence_done;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    fetch_buffer_if imem ();

    fetch_buffer dut (
        .rst         (rst),
        .clk         (clk),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .fence_valid (fence_valid),
        .fence_done  (fence_done),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_pc     (inst_pc),
        .inst_data   (inst_data),
        .imem        (imem)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[31:16], a[15:0] ^ 16'hC3A5};
    endfunction

    // TIM model and scoreboard state
    int           tim_lat = 1;
    bit           tim_pend = 0;
    int           tim_cnt = 0;
    bit           tim_fence = 0;
    logic [31:0]  tim_addr = 32'h0;
    logic [31:0]  tim_exp_pc = 32'h0;
    bit           rsp_now = 0;
    bit           rsp_fence = 0;
    logic [31:0]  rsp_exp_pc = 32'h0;
    logic [31:0]  exp_pc = RESET_PC;
    bit           sb_discard = 0;
    fb_entry_type sb_q[$];
    int           req_cnt = 0;
    int           fence_cnt = 0;
    logic [31:0]  last_req_addr = 32'h0;

    initial begin : tim_monitor
        fb_entry_type e;
        imem.imem_out = '0;
        forever begin
            @(negedge clk);
            imem.imem_out = '0;
            rsp_now = 0;
            if (tim_pend) begin
                tim_cnt--;
                if (tim_cnt <= 0) begin
                    imem.imem_out.mem_ready = 1'b1;
                    imem.imem_out.mem_rdata = tim_fence ? 32'h0 : data_of(tim_addr);
                    rsp_now    = 1;
                    rsp_fence  = tim_fence;
                    rsp_exp_pc = tim_exp_pc;
                    tim_pend   = 0;
                end
            end
            #1;
            if (rst && inst_valid && inst_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_pop", inst_pc, 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", inst_pc, e.pc);
                    chk("sb_data", inst_data, e.data);
                end
            end
            #1;
            if (!rst) begin
                sb_q.delete();
                sb_discard = 0;
                exp_pc     = RESET_PC;
            end else begin
                if (redir_valid) begin
                    sb_q.delete();
                    if (tim_pend && !tim_fence) sb_discard = 1;
                end
                if (rsp_now && !rsp_fence) begin
                    if (!redir_valid && !sb_discard)
                        sb_q.push_back('{pc: rsp_exp_pc, data: data_of(rsp_exp_pc)});
                    sb_discard = 0;
                end
                if (imem.imem_in.mem_valid) begin
                    chk("one_outstanding", {31'h0, tim_pend}, 32'h0);
                    if (imem.imem_in.mem_fence) begin
                        fence_cnt++;
                        tim_fence = 1;
                    end else begin
                        chk("req_addr", imem.imem_in.mem_addr, exp_pc);
                        chk("req_wr_fields", imem.imem_in.mem_wdata | {28'h0, imem.imem_in.mem_wstrb}, 32'h0);
                        tim_fence  = 0;
                        tim_exp_pc = exp_pc;
                        exp_pc     = exp_pc + 32'd4;
                        req_cnt++;
                        last_req_addr = imem.imem_in.mem_addr;
                    end
                    tim_addr = imem.imem_in.mem_addr;
                    tim_pend = 1;
                    tim_cnt  = tim_lat;
                end
                if (redir_valid) exp_pc = redir_pc & ~32'h3;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        mv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[8];

    task automatic do_reset();
        rst         = 1'b0;
        redir_valid = 1'b0;
        fence_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_mv(input string name, input int limit);
        bit seen = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #1;
            if (imem.imem_in.mem_valid) begin seen = 1; break; end
        end
        if (!seen) chk(name, 32'h0, 32'h1);
    endtask

    task automatic wait_iv(input string name, input int limit);
        bit seen = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #1;
            if (inst_valid) begin seen = 1; break; end
        end
        if (!seen) chk(name, 32'h0, 32'h1);
    endtask

    initial begin : stim
        bit found;
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

        // Streaming after reset, 1-cycle TIM, decode always ready
        tim_lat = 1; inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            rst = tbl[i].rst; inst_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_mem_valid", i), {31'h0, imem.imem_in.mem_valid}, {31'h0, tbl[i].mv});
            if (tbl[i].mv) chk($sformatf("tbl%0d_mem_addr", i), imem.imem_in.mem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].iv});
            if (tbl[i].iv) chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].ipc);
            if (i == 0) chk("reset_outputs", {inst_pc | inst_data, 31'h0, fence_done}, 64'h0);
        end
        repeat (6) @(negedge clk);

        // Back-pressure: four fetches fill the queue, then stall
        tim_lat = 1; inst_ready = 1'b0;
        do_reset();
        req_cnt = 0;
        rst = 1'b1;
        repeat (16) @(negedge clk);
        #1;
        chk("bp_req_count", req_cnt, 32'd4);
        chk("bp_idle", {31'h0, imem.imem_in.mem_valid}, 32'h0);
        chk("bp_inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("bp_head_pc", inst_pc, 32'h0);
        @(negedge clk);
        inst_ready = 1'b1;
        for (int k = 0; k < 20 && req_cnt < 5; k++) @(negedge clk);
        chk("bp_resume_count", req_cnt, 32'd5);
        chk("bp_resume_addr", last_req_addr, 32'h10);
        repeat (16) @(negedge clk);

        // Redirect while the 0x8 fetch is outstanding
        tim_lat = 3; inst_ready = 1'b0;
        do_reset();
        rst = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (imem.imem_in.mem_valid && imem.imem_in.mem_addr == 32'h8) begin found = 1; break; end
        end
        if (!found) chk("redir_wait_req8", 32'h0, 32'h1);
        @(negedge clk);
        redir_valid = 1'b1; redir_pc = 32'h1002;
        @(negedge clk);
        redir_valid = 1'b0;
        #1;
        chk("redir_flushed", {31'h0, inst_valid}, 32'h0);
        chk("redir_no_req_wait", {31'h0, imem.imem_in.mem_valid}, 32'h0);
        wait_mv("redir_next_req_timeout", 10);
        chk("redir_next_addr", imem.imem_in.mem_addr, 32'h1000);
        chk("redir_drop", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
        inst_ready = 1'b1;
        wait_iv("redir_head_timeout", 10);
        chk("redir_head_pc", inst_pc, 32'h1000);
        repeat (10) @(negedge clk);

        // fence.i arriving while a fetch is outstanding
        tim_lat = 2; inst_ready = 1'b1;
        do_reset();
        fence_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        fence_valid = 1'b1;
        @(negedge clk);
        fence_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (imem.imem_in.mem_valid && imem.imem_in.mem_fence) begin found = 1; break; end
        end
        chk("fence_issue", {31'h0, found}, 32'h1);
        chk("fence_prior_pushed", {31'h0, inst_valid}, 32'h1);
        chk("fence_prior_pc", inst_pc, 32'h0);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (imem.imem_out.mem_ready) begin found = 1; break; end
        end
        chk("fence_ack_seen", {31'h0, found}, 32'h1);
        chk("fence_done_not_early", {31'h0, fence_done}, 32'h0);
        @(negedge clk); #1;
        chk("fence_done_pulse", {31'h0, fence_done}, 32'h1);
        chk("fence_resume_addr", imem.imem_in.mem_addr, 32'h4);
        @(negedge clk); #1;
        chk("fence_done_once", {31'h0, fence_done}, 32'h0);
        chk("fence_count", fence_cnt, 32'd1);
        repeat (8) @(negedge clk);

        // Reset asserted while a fetch is outstanding
        tim_lat = 2; inst_ready = 1'b1;
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {imem.imem_in.mem_valid, inst_valid, fence_done, 29'h0}, 32'h0);
        chk("rst_mid_inst", inst_pc | inst_data, 32'h0);
        @(negedge clk); #1;
        chk("rst_rsp_in_reset", {31'h0, imem.imem_out.mem_ready}, 32'h1);
        chk("rst_mid_outputs2", {imem.imem_in.mem_valid, inst_valid, fence_done, 29'h0}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_first_req_valid", {31'h0, imem.imem_in.mem_valid}, 32'h1);
        chk("rst_first_req_addr", imem.imem_in.mem_addr, RESET_PC);
        chk("rst_no_push", {31'h0, inst_valid}, 32'h0);
        repeat (8) @(negedge clk);

        // Redirect coinciding with the response
        tim_lat = 2; inst_ready = 1'b1;
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redir_valid = 1'b1; redir_pc = 32'h2000;
        #1;
        chk("simul_rsp_same_cycle", {31'h0, imem.imem_out.mem_ready}, 32'h1);
        @(negedge clk);
        redir_valid = 1'b0;
        #1;
        chk("simul_no_push", {31'h0, inst_valid}, 32'h0);
        chk("simul_next_valid", {31'h0, imem.imem_in.mem_valid}, 32'h1);
        chk("simul_next_addr", imem.imem_in.mem_addr, 32'h2000);
        wait_iv("simul_head_timeout", 10);
        chk("simul_head_pc", inst_pc, 32'h2000);
        repeat (6) @(negedge clk);

        // Redirect in FETCH to the top of the address space, then wrap
        tim_lat = 1; inst_ready = 1'b1;
        do_reset();
        rst = 1'b1;
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFF;
        #1;
        chk("redir_fetch_no_issue", {31'h0, imem.imem_in.mem_valid}, 32'h0);
        @(negedge clk);
        redir_valid = 1'b0;
        #1;
        chk("wrap_first_valid", {31'h0, imem.imem_in.mem_valid}, 32'h1);
        chk("wrap_first_addr", imem.imem_in.mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk); #1;
        chk("wrap_second_addr", imem.imem_in.mem_addr, 32'h0);
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
